// File: rtl/fan_temp_ctrl.sv
// Temperature-to-fan-speed controller: 4-deep moving average, hysteretic level FSM,
// ramp-limited speed output and sensor-silence fault that forces full speed.
module fan_temp_ctrl #(
  parameter int unsigned T_LOW_ON  = 25,
  parameter int unsigned T_MED_ON  = 30,
  parameter int unsigned T_HIGH_ON = 35,
  parameter int unsigned HYST      = 2,
  parameter int unsigned SPD_LOW   = 64,
  parameter int unsigned SPD_MED   = 128,
  parameter int unsigned SPD_HIGH  = 255,
  parameter int unsigned RAMP_DIV  = 256,
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] temp,
  input  logic       temp_valid,
  input  logic       enable,
  output logic [7:0] speed,
  output logic [1:0] level,
  output logic       fault
);

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MED  = 2'd2,
    LVL_HIGH = 2'd3
  } level_e;

  localparam logic [7:0] LOW_ON   = 8'(T_LOW_ON);
  localparam logic [7:0] MED_ON   = 8'(T_MED_ON);
  localparam logic [7:0] HIGH_ON  = 8'(T_HIGH_ON);
  localparam logic [7:0] LOW_OFF  = 8'(T_LOW_ON - HYST);
  localparam logic [7:0] MED_OFF  = 8'(T_MED_ON - HYST);
  localparam logic [7:0] HIGH_OFF = 8'(T_HIGH_ON - HYST);
  localparam logic [8:0] STEP     = 9'(RAMP_STEP);
  localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // Averaging window
  // ---------------------------------------------------------------------------
  logic [7:0] win [4];
  logic       filled;
  logic [9:0] win_sum;

  // NOTE: the window is a small register array, so it can take the async reset
  // like any other flop; larger storage would normally be left unreset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift work.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < 4; i++) win[i] <= '0;
      filled <= 1'b0;
    end else if (temp_valid) begin
      if (!filled) begin
        // Prime the whole window so the first average is the first sample.
        for (int i = 0; i < 4; i++) win[i] <= temp;
        filled <= 1'b1;
      end else begin
        win[0] <= temp;
        for (int i = 1; i < 4; i++) win[i] <= win[i-1];
      end
    end
  end

  always_comb begin
    win_sum = 10'(win[0]) + 10'(win[1]) + 10'(win[2]) + 10'(win[3]);
  end

  // ---------------------------------------------------------------------------
  // Registered average, one cycle after the window update
  // ---------------------------------------------------------------------------
  logic       win_upd;
  logic       avg_valid;
  logic [7:0] avg;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      win_upd   <= 1'b0;
      avg_valid <= 1'b0;
      avg       <= '0;
    end else begin
      win_upd   <= temp_valid;
      avg_valid <= win_upd;
      if (win_upd) avg <= 8'(win_sum >> 2);
    end
  end

  // ---------------------------------------------------------------------------
  // Level FSM: at most one step per evaluated average
  // ---------------------------------------------------------------------------
  level_e state_q, state_d;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state_q <= LVL_OFF;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = LVL_OFF;
    end else if (avg_valid) begin
      case (state_q)
        LVL_OFF:  if (avg >= LOW_ON) state_d = LVL_LOW;
        LVL_LOW: begin
          if (avg >= MED_ON)       state_d = LVL_MED;
          else if (avg < LOW_OFF)  state_d = LVL_OFF;
        end
        LVL_MED: begin
          if (avg >= HIGH_ON)      state_d = LVL_HIGH;
          else if (avg < MED_OFF)  state_d = LVL_LOW;
        end
        LVL_HIGH: if (avg < HIGH_OFF) state_d = LVL_MED;
        default:  state_d = LVL_OFF;
      endcase
    end
  end

  assign level = state_q;

  // ---------------------------------------------------------------------------
  // Target speed
  // ---------------------------------------------------------------------------
  logic [7:0] target;

  always_comb begin
    target = '0;
    if (!enable) begin
      target = '0;
    end else if (fault) begin
      target = 8'd255;
    end else begin
      case (state_q)
        LVL_LOW:  target = 8'(SPD_LOW);
        LVL_MED:  target = 8'(SPD_MED);
        LVL_HIGH: target = 8'(SPD_HIGH);
        default:  target = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Ramp limiter: speed moves at most RAMP_STEP once per RAMP_DIV cycles
  // ---------------------------------------------------------------------------
  logic [RC_W-1:0] ramp_cnt;
  logic            tick;
  logic [8:0]      up_sum;
  logic [7:0]      speed_d;

  assign tick = (ramp_cnt == RC_W'(RAMP_DIV - 1));

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)     ramp_cnt <= '0;
    else if (tick) ramp_cnt <= '0;
    else           ramp_cnt <= ramp_cnt + 1'b1;
  end

  // Nine-bit arithmetic keeps the step from wrapping past 255 or below 0.
  always_comb begin
    up_sum  = {1'b0, speed} + STEP;
    speed_d = speed;
    if (speed < target) begin
      speed_d = (up_sum >= {1'b0, target}) ? target : up_sum[7:0];
    end else if (speed > target) begin
      speed_d = ({1'b0, speed} >= ({1'b0, target} + STEP)) ? 8'(speed - 8'(RAMP_STEP)) : target;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)     speed <= '0;
    else if (tick) speed <= speed_d;
  end

  // ---------------------------------------------------------------------------
  // Sensor timeout: a strobe on the edge that would expire the count wins
  // ---------------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      to_cnt <= '0;
      fault  <= 1'b0;
    end else if (temp_valid) begin
      to_cnt <= '0;
      fault  <= 1'b0;
    end else if (to_cnt >= TO_W'(TIMEOUT - 1)) begin
      to_cnt <= TO_W'(TIMEOUT);
      fault  <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fan_temp_ctrl.sv
// Directed bench for fan_temp_ctrl: latency, averaging, hysteresis, ramp limits,
// sensor timeout and disable, all with hand-computed expectations.
module tb_fan_temp_ctrl;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic [7:0] temp = '0;
  logic       temp_valid = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] speed;
  logic [1:0] level;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_chg = 0;

  fan_temp_ctrl #(.TIMEOUT(1000)) dut (
    .clk(clk),
    .arst(arst),
    .temp(temp),
    .temp_valid(temp_valid),
    .enable(enable),
    .speed(speed),
    .level(level),
    .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled on the following posedge (edge N)
  // and the task returns at the negedge after edge N.
  task automatic strobe(input logic [7:0] t);
    temp       = t;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  // Level is observed after edge N+2, when the FSM has consumed the average.
  task automatic eval_check(input logic [7:0] t, input logic [1:0] exp, input string tag);
    strobe(t);
    repeat (2) @(negedge clk);
    check(tag, 32'(level), 32'(exp));
  endtask

  // Waits (bounded) for the next speed change, optionally sending one keepalive strobe.
  task automatic wait_change(input logic [7:0] exp, input bit keep, input logic [7:0] keep_t,
                             input bit check_iv, input string tag);
    logic [7:0] prev;
    bit seen;
    prev = speed;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (keep && i == 0) begin
        temp       = keep_t;
        temp_valid = 1'b1;
      end
      @(negedge clk);
      temp_valid = 1'b0;
      if (speed !== prev) seen = 1'b1;
    end
    check(tag, 32'(speed), 32'(exp));
    if (check_iv) check({tag, " interval"}, 32'(cyc - last_chg), 32'd256);
    last_chg = cyc;
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst speed", 32'(speed), 32'd0);
    check("rst level", 32'(level), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    arst = 1'b1;
    @(negedge clk);
    check("post_rst speed", 32'(speed), 32'd0);

    // ---------------- first-sample fill and latency ----------------
    strobe(8'd30);
    check("lat N level", 32'(level), 32'd0);
    @(negedge clk);
    check("lat N+1 level", 32'(level), 32'd0);
    @(negedge clk);
    check("lat N+2 level", 32'(level), 32'd1);
    eval_check(8'd30, 2'd2, "fill to MED");
    for (int k = 1; k <= 16; k++)
      wait_change(8'(8 * k), 1'b1, 8'd30, k > 1, $sformatf("ramp_up[%0d]", k));
    repeat (300) @(negedge clk);
    check("med hold speed", 32'(speed), 32'd128);

    // ---------------- async reset mid-ramp ----------------
    eval_check(8'd40, 2'd2, "avg32 holds MED");
    eval_check(8'd40, 2'd3, "avg35 to HIGH");
    wait_change(8'd136, 1'b1, 8'd40, 1'b0, "ramp_high");
    @(posedge clk);
    #2 arst = 1'b0;
    #1;
    check("async speed", 32'(speed), 32'd0);
    check("async level", 32'(level), 32'd0);
    check("async fault", 32'(fault), 32'd0);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    repeat (300) @(negedge clk);
    check("idle speed", 32'(speed), 32'd0);
    check("idle level", 32'(level), 32'd0);
    check("idle fault", 32'(fault), 32'd0);

    // ---------------- averaging ----------------
    eval_check(8'd20, 2'd0, "avg20 a");
    eval_check(8'd20, 2'd0, "avg20 b");
    eval_check(8'd20, 2'd0, "avg20 c");
    eval_check(8'd40, 2'd1, "avg25 LOW");

    // ---------------- hysteresis ----------------
    eval_check(8'd40, 2'd2, "avg30 MED");
    eval_check(8'd16, 2'd2, "avg29 stays MED");
    eval_check(8'd12, 2'd1, "avg27 to LOW");
    eval_check(8'd24, 2'd1, "avg23 stays LOW");
    eval_check(8'd36, 2'd0, "avg22 to OFF");

    // ---------------- timeout and saturation ----------------
    strobe(8'd0);
    repeat (999) @(negedge clk);
    check("fault at 999", 32'(fault), 32'd0);
    @(negedge clk);
    check("fault at 1000", 32'(fault), 32'd1);
    check("fault level", 32'(level), 32'd0);
    for (int k = 1; k <= 32; k++)
      wait_change((k == 32) ? 8'd255 : 8'(8 * k), 1'b0, 8'd0, k > 1, $sformatf("ramp_fault[%0d]", k));
    repeat (300) @(negedge clk);
    check("sat hold", 32'(speed), 32'd255);
    strobe(8'd0);
    check("fault clear", 32'(fault), 32'd0);
    repeat (999) @(negedge clk);
    check("fault pre race", 32'(fault), 32'd0);
    strobe(8'd0);
    check("strobe wins race", 32'(fault), 32'd0);
    @(negedge clk);
    check("after race", 32'(fault), 32'd0);

    // ---------------- disable / re-enable ----------------
    eval_check(8'd40, 2'd0, "avg10 OFF");
    eval_check(8'd40, 2'd0, "avg20 OFF");
    eval_check(8'd40, 2'd1, "avg30 LOW");
    eval_check(8'd40, 2'd2, "avg40 MED");
    eval_check(8'd40, 2'd3, "avg40 HIGH");
    for (int i = 0; i < 12000; i++) begin
      if (i % 256 == 0) begin
        temp       = 8'd40;
        temp_valid = 1'b1;
      end
      @(negedge clk);
      temp_valid = 1'b0;
      if (speed == 8'd255) break;
    end
    check("high full", 32'(speed), 32'd255);
    enable = 1'b0;
    @(negedge clk);
    check("disable level", 32'(level), 32'd0);
    for (int k = 1; k <= 32; k++)
      wait_change((k == 32) ? 8'd0 : 8'(255 - 8 * k), 1'b1, 8'd40, k > 1, $sformatf("ramp_down[%0d]", k));
    repeat (300) @(negedge clk);
    check("floor", 32'(speed), 32'd0);
    check("disabled hold", 32'(level), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("reenable off", 32'(level), 32'd0);
    eval_check(8'd40, 2'd1, "reen LOW");
    eval_check(8'd40, 2'd2, "reen MED");
    eval_check(8'd40, 2'd3, "reen HIGH");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
